// File: rtl/ide_devctrl_if.sv
// Port 0x3F6 strobe pair plus the IDE-core/PIC side signals of the Device Control stage.
// The slave modport is the ide_devctrl view; the master modport drives it.
interface ide_devctrl_if;
  logic       ide_3f6_write;
  logic [7:0] ide_3f6_writedata;
  logic       ide_3f6_read;
  logic [7:0] ide_3f6_readdata;
  logic [7:0] status_in;
  logic       irq_req;
  logic       irq_clear;
  logic       irq;
  logic       srst_active;
  logic       srst_done;
  logic       nien;

  modport slave (
    input  ide_3f6_write,
    input  ide_3f6_writedata,
    input  ide_3f6_read,
    input  status_in,
    input  irq_req,
    input  irq_clear,
    output ide_3f6_readdata,
    output irq,
    output srst_active,
    output srst_done,
    output nien
  );

  modport master (
    output ide_3f6_write,
    output ide_3f6_writedata,
    output ide_3f6_read,
    output status_in,
    output irq_req,
    output irq_clear,
    input  ide_3f6_readdata,
    input  irq,
    input  srst_active,
    input  srst_done,
    input  nien
  );
endinterface

// File: rtl/ide_devctrl.sv
// Device Control / Alternate Status stage at port 0x3F6: nIEN storage, ATA soft-reset
// sequencing for the IDE core, interrupt gating toward the PIC and Alternate Status readback.
module ide_devctrl #(
  parameter int unsigned BUSY_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  ide_devctrl_if.slave  io_bus
);

  localparam int unsigned     CW       = $clog2(BUSY_CYCLES);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [7:0]      ALT_BSY  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_nien;
  logic          r_pending;
  logic          r_irq;
  logic          r_srst_active;
  logic          r_srst_done;
  logic [7:0]    r_readdata;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_done_nxt;
  logic          w_nien_nxt;
  logic          w_pending_nxt;
  logic          w_irq_nxt;
  logic          w_enter_held;

  wire w_wr       = io_bus.ide_3f6_write;
  wire w_srst_bit = io_bus.ide_3f6_writedata[2];
  wire w_nien_bit = io_bus.ide_3f6_writedata[1];

  // Read strobe and undecoded Device Control bits have no effect on this stage.
  wire w_unused = ^{io_bus.ide_3f6_read, io_bus.ide_3f6_writedata[7:3],
                    io_bus.ide_3f6_writedata[0]};

  // Soft-reset sequencer next state and release counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr && w_srst_bit) begin
          w_state_nxt = ST_HELD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (w_wr && !w_srst_bit) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      ST_WAIT: begin
        // Re-asserting SRST abandons the release: back to HELD, no done pulse.
        if (w_wr && w_srst_bit) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // nIEN, pending flag and the gated interrupt level, all computed from next-cycle values.
  always_comb begin
    w_nien_nxt    = r_nien;
    w_pending_nxt = r_pending;
    w_enter_held  = (w_state_nxt == ST_HELD) && (r_state != ST_HELD);
    if (w_wr) begin
      w_nien_nxt = w_nien_bit;
    end else begin
      w_nien_nxt = r_nien;
    end
    if (w_enter_held) begin
      w_pending_nxt = 1'b0;
    end else if (io_bus.irq_req && (r_state == ST_IDLE)) begin
      w_pending_nxt = 1'b1;
    end else if (io_bus.irq_clear) begin
      w_pending_nxt = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
    w_irq_nxt = w_pending_nxt & ~w_nien_nxt & (w_state_nxt == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= CNT_ZERO;
      r_nien        <= 1'b0;
      r_pending     <= 1'b0;
      r_irq         <= 1'b0;
      r_srst_active <= 1'b0;
      r_srst_done   <= 1'b0;
      r_readdata    <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_nien        <= w_nien_nxt;
      r_pending     <= w_pending_nxt;
      r_irq         <= w_irq_nxt;
      r_srst_active <= (w_state_nxt != ST_IDLE);
      r_srst_done   <= w_done_nxt;
      r_readdata    <= (r_state == ST_IDLE) ? io_bus.status_in : ALT_BSY;
    end
  end

  assign io_bus.ide_3f6_readdata = r_readdata;
  assign io_bus.irq              = r_irq;
  assign io_bus.srst_active      = r_srst_active;
  assign io_bus.srst_done        = r_srst_done;
  assign io_bus.nien             = r_nien;

endmodule

// File: tb/tb_ide_devctrl.sv
// Self-checking bench for ide_devctrl: directed scenarios then random traffic, all checked
// every cycle against a timestamp-based behavioural model of the 0x3F6 stage.
module tb_ide_devctrl;
  localparam int B = 4;

  logic clk;
  logic rst_n;
  ide_devctrl_if bus ();

  ide_devctrl #(.BUSY_CYCLES(B)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: device busy flag, edge index at which the release completes (-1 = held/none)
  int         edge_k       = 0;
  bit         m_busy       = 1'b0;
  int         m_release_at = -1;
  bit         m_nien       = 1'b0;
  bit         m_pend       = 1'b0;
  logic [7:0] status_v     = 8'h50;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy       = 1'b0;
    m_release_at = -1;
    m_nien       = 1'b0;
    m_pend       = 1'b0;
  endtask

  // One clock: apply inputs, advance the model by the edge, compare every output.
  task automatic step(input bit wr, input logic [7:0] wd, input bit rd,
                      input bit req, input bit clr);
    bit         busy_before;
    bit         exp_done;
    bit         entered;
    logic [7:0] exp_rd;
    bus.ide_3f6_write     = wr;
    bus.ide_3f6_writedata = wd;
    bus.ide_3f6_read      = rd;
    bus.irq_req           = req;
    bus.irq_clear         = clr;
    bus.status_in         = status_v;
    @(posedge clk);
    edge_k++;
    busy_before = m_busy;
    exp_rd      = busy_before ? 8'h80 : status_v;
    exp_done    = 1'b0;
    entered     = 1'b0;
    if (wr && wd[2]) begin
      entered      = !m_busy || (m_release_at >= 0);
      m_busy       = 1'b1;
      m_release_at = -1;
    end else if (m_busy && (m_release_at < 0) && wr) begin
      m_release_at = edge_k + B;
    end else if (m_busy && (m_release_at >= 0) && (edge_k == m_release_at)) begin
      m_busy       = 1'b0;
      m_release_at = -1;
      exp_done     = 1'b1;
    end
    if (entered) m_pend = 1'b0;
    else if (!busy_before && req) m_pend = 1'b1;
    else if (clr) m_pend = 1'b0;
    if (wr) m_nien = wd[1];
    #1;
    check_eq("readdata", bus.ide_3f6_readdata, exp_rd);
    check_eq("srst_active", {7'd0, bus.srst_active}, {7'd0, m_busy});
    check_eq("srst_done", {7'd0, bus.srst_done}, {7'd0, exp_done});
    check_eq("nien", {7'd0, bus.nien}, {7'd0, m_nien});
    check_eq("irq", {7'd0, bus.irq}, {7'd0, m_pend & ~m_nien & ~m_busy});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // After a 0x00 release write, count cycles until srst_done (bounded).
  task automatic measure_release(input string tag);
    int  c;
    bit  seen;
    c    = 1;
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      if (bus.srst_done) seen = 1'b1;
      else begin
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        c++;
      end
    end
    check_eq(tag, seen ? 8'(c) : 8'hFF, 8'(B + 1));
  endtask

  initial begin
    int  done_seen;
    rst_n                 = 1'b0;
    bus.ide_3f6_write     = 1'b0;
    bus.ide_3f6_writedata = 8'h00;
    bus.ide_3f6_read      = 1'b0;
    bus.irq_req           = 1'b0;
    bus.irq_clear         = 1'b0;
    bus.status_in         = 8'h50;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_irq", {7'd0, bus.irq}, 8'h00);
    check_eq("rst_active", {7'd0, bus.srst_active}, 8'h00);
    check_eq("rst_done", {7'd0, bus.srst_done}, 8'h00);
    check_eq("rst_nien", {7'd0, bus.nien}, 8'h00);
    check_eq("rst_rd", bus.ide_3f6_readdata, 8'h00);
    rst_n = 1'b1;
    #1;
    check_eq("rel_rd", bus.ide_3f6_readdata, 8'h00);
    idle(1);
    check_eq("rel_rd_next", bus.ide_3f6_readdata, 8'h50);

    // Soft reset: hold 10 cycles, release, single srst_done B+1 cycles later.
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    idle(10);
    check_eq("held_rd", bus.ide_3f6_readdata, 8'h80);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    measure_release("release_latency");
    idle(3);

    // Re-assert during WAIT, then a fresh release restarts the full count.
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    idle(B + 2);
    check_eq("reassert_held", {7'd0, bus.srst_active}, 8'h01);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    measure_release("restart_latency");
    idle(2);

    // Interrupt masking and simultaneous set/clear.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("irq_set", {7'd0, bus.irq}, 8'h01);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    check_eq("irq_masked", {7'd0, bus.irq}, 8'h00);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("irq_unmasked", {7'd0, bus.irq}, 8'h01);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("irq_cleared", {7'd0, bus.irq}, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("irq_after_altread", {7'd0, bus.irq}, 8'h01);
    // Combined nIEN+SRST write, then SRST entry clears pending.
    step(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(B + 2);
    check_eq("pend_cleared", {7'd0, bus.irq}, 8'h00);

    // Async reset in WAIT with cnt=2: outputs drop without a clock edge, no srst_done.
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1);
    bus.ide_3f6_write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_active", {7'd0, bus.srst_active}, 8'h00);
    check_eq("async_rd", bus.ide_3f6_readdata, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < B + 4; i++) begin
      idle(1);
      if (bus.srst_done) done_seen++;
    end
    check_eq("async_no_done", 8'(done_seen), 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      status_v = 8'($urandom);
      step(($urandom_range(0, 9) == 0), 8'($urandom), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ide_devctrl.md
# ide_devctrl

Device Control / Alternate Status stage for the IDE channel at I/O port 0x3F6. It sits directly downstream of the 0x3F0–0x3F7 port decoder and consumes that decoder's 0x3F6 read/write strobe pair. It holds the write-only Device Control register (nIEN, SRST) and sequences an ATA software reset for the IDE core. It also gates the IDE interrupt toward the PIC and returns the Alternate Status byte on reads.

## Interface
- BUSY_CYCLES, 64, clk cycles BSY stays asserted after SRST is released; legal range 2..65535
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ide_3f6_write  in  1  one-cycle write strobe for port 0x3F6
- ide_3f6_writedata  in  8  write data, valid with ide_3f6_write
- ide_3f6_read  in  1  read strobe for port 0x3F6; causes no side effect
- ide_3f6_readdata  out  8  Alternate Status, registered and refreshed every cycle
- status_in  in  8  live Status register from the IDE core
- irq_req  in  1  one-cycle pulse from the core requesting an interrupt
- irq_clear  in  1  one-cycle pulse from the core when Status (0x1F7) is read
- irq  out  1  interrupt level to the PIC
- srst_active  out  1  holds the IDE core in soft reset
- srst_done  out  1  one-cycle pulse; the core loads its reset signature
- nien  out  1  current nIEN bit

## Operation
- Device Control decode on ide_3f6_write: bit1 is nIEN and is stored; bit2 is SRST and drives the FSM; all other bits are ignored.
- FSM states are IDLE, HELD and WAIT.
  - IDLE: a write with SRST=1 goes to HELD.
  - HELD: a write with SRST=0 goes to WAIT and loads cnt = BUSY_CYCLES-1. A write with SRST=1 stays in HELD.
  - WAIT: a write with SRST=1 returns to HELD and drops the count, with no srst_done. Otherwise, cnt==0 goes to IDLE and pulses srst_done for one cycle; any other cnt decrements.
- srst_active = (state != IDLE), registered.
- Alternate Status source: 0x80 (BSY only) in HELD or WAIT; status_in in IDLE.
- The ide_3f6_read strobe is accepted and ignored. Alternate Status reads never clear the pending interrupt.
- Interrupt pending flag:
  - Set by irq_req and cleared by irq_clear. If both occur in the same cycle, set wins.
  - Forced clear on entry to HELD. irq_req is ignored while state != IDLE.
- irq = pending & ~nien & (state==IDLE), registered.
  - nIEN masks only the output; the pending flag is kept.
  - Clearing nIEN while pending raises irq on the next cycle.
- cnt width is clog2(BUSY_CYCLES) bits, unsigned, and is never decremented below 0.

## Timing
- Reset values:
  - State is IDLE; nien=0, pending=0, cnt=0.
  - Outputs: ide_3f6_readdata=0x00, irq=0, srst_active=0, srst_done=0.
- Write strobe at edge N: the register/state update is visible at N+1, and srst_active follows at N+1.
- ide_3f6_readdata follows its source with 1 cycle of latency. It is valid every cycle, so the upstream registered read capture sees a stable value when the read strobe is held for 2 cycles.
- SRST release: the SRST=0 write at edge N causes srst_done high during cycle N+BUSY_CYCLES+1, with srst_active falling at the same edge.
- irq_req at edge N gives irq=1 from N+1, provided IDLE and nien=0. irq_clear at N gives irq=0 from N+1.
- rst_n asserted mid-reset: immediately IDLE with all outputs at reset values; no srst_done is pulsed.
- A write that sets nIEN and SRST together applies both in the same cycle.

## Test plan
- Reset: hold rst_n=0, release, status_in=0x50 -> irq=0, srst_active=0; readdata=0x00 right after release, then 0x50 after 1 cycle.
- Soft reset with BUSY_CYCLES=4: write 0x04, wait 10 cycles, write 0x00 -> readdata=0x80 and srst_active=1 throughout; srst_done is a single pulse 5 cycles after the 0x00 write; readdata returns to status_in next cycle.
- Re-assert during WAIT: write 0x04, 0x00, then 0x04 two cycles later -> state HELD, no srst_done; a subsequent 0x00 restarts the full 4-cycle count.
- Interrupt masking: irq_req -> irq=1. Write 0x02 -> irq=0 with pending kept. Write 0x00 -> irq=1. irq_clear -> irq=0.
- Simultaneous irq_req and irq_clear in the same cycle -> pending=1, irq=1; alternate status reads leave irq=1.
- Async reset in WAIT with cnt=2 -> srst_active drops to 0 without waiting for a clock edge; no srst_done pulse follows.
